db_read_arbiter: RTL and testbench
==================================

Name: db_read_arbiter

Overview:
- Owns the read-return path of the DSP external 16-bit data bus. It replaces the fixed priority chain of `data_from_XX_avail` selects with a sequenced arbiter.
- Each read cycle runs in a fixed order: settle, sample source claims, grant one source, drive, then a guaranteed turnaround.
- Multiple-claim conflicts, empty reads and stuck reads are detected and counted. A status register that the DSP can read reports them.
- Sits between the bus top level (which owns the `db` tri-state pad) and the application sub-modules.

Parameters:
- `NUM_SRC`, 8: number of sub-module read sources; legal range 1..16.
- `STAT_ADDR`, 8'hF0: low-byte address of the arbiter status register.
- `TURN_CYC`, 1: forced bus-idle cycles after each read; legal range 1..7.
- `TIMEOUT`, 255: maximum DRIVE cycles before the watchdog releases the bus; legal range 2..255.
- `DEFAULT_DATA`, 16'h3333: value driven when no source claims the read.

Ports:
- `xclk`  in  1  master clock (DSP external bus clock).
- `reset`  in  1  asynchronous, active-low reset.
- `read_qualified`  in  1  (!re & !cs) from bus top level.
- `write_qualified`  in  1  (!we_del & !cs) from bus top level.
- `ab`  in  8  address bus, low byte.
- `db_in`  in  16  data bus input copy.
- `src_avail`  in  NUM_SRC  per-source claim; bit i = source i.
- `src_data`  in  16*NUM_SRC  source i's data occupies bits [16i+15:16i].
- `db_out`  out  16  registered data for the `db` pad.
- `db_oe`  out  1  registered output enable; top level drives `db` = `db_oe` ? `db_out` : Z.
- `grant`  out  NUM_SRC  registered one-hot grant; all zero when no source is granted.
- `conflict_irq`  out  1  one-cycle pulse per detected conflict.

Behaviour:
- Reset (asynchronous, active low):
  - state = IDLE; `db_oe` = 0, `db_out` = 0, `grant` = 0, `conflict_irq` = 0.
  - Status counters and sticky flags cleared.
  - Reset asserted mid-read releases the bus immediately (`db_oe` goes low asynchronously).
- State machine: IDLE, SETTLE, DRIVE, RELEASE, TURN.
- IDLE:
  - `read_qualified` = 1 -> SETTLE next edge.
  - `write_qualified` is handled in every state (status clear, below).
- SETTLE, one cycle, gives sub-modules time to assert `src_avail`. At the exit edge:
  - If `ab` == `STAT_ADDR`: `grant` = 0, `db_out` = status word.
  - Else if `src_avail` != 0: grant the lowest-index set bit; `db_out` = that source's data.
  - Else: `grant` = 0, `db_out` = `DEFAULT_DATA`, `nosrc_sticky` set.
  - If more than one `src_avail` bit is set (non-status address): the conflict counter increments (saturating at 8'hFF), `conflict_irq` pulses for one cycle and `last_winner` records the granted index.
  - If `read_qualified` = 0 at the exit edge (aborted read): go to TURN with `db_oe` = 0.
  - Otherwise go to DRIVE with `db_oe` = 1. First data appears on `db` 2 edges after `read_qualified` rises.
- DRIVE:
  - `db_out` refreshes every edge from the granted source, or from the status word or default.
  - The grant is frozen; changes to `src_avail` are ignored until the next read.
  - `read_qualified` = 0 -> TURN, `db_oe` = 0 at that edge.
  - A watchdog counter counts DRIVE cycles. On reaching `TIMEOUT`: `db_oe` = 0, `grant` = 0, `timeout_sticky` set, go to RELEASE.
- RELEASE: hold `db_oe` = 0 until `read_qualified` = 0, then go to TURN.
- TURN:
  - Count `TURN_CYC` cycles with `db_oe` = 0 and `grant` = 0; `read_qualified` is ignored.
  - On the final cycle: `read_qualified` = 1 -> SETTLE, else -> IDLE.
- Status word:
  - [7:0] conflict count.
  - [8] `timeout_sticky`.
  - [9] `nosrc_sticky`.
  - [11:10] 0.
  - [15:12] `last_winner` (index of the last conflict winner; 0 after reset).
- Status clear:
  - Triggered on any cycle with `write_qualified` = 1, `ab` == `STAT_ADDR` and `db_in[0]` = 1.
  - Clears count, both stickies and `last_winner`.
  - Clearing is idempotent across a multi-cycle write.
- Same-edge clear and event: the clear is applied first, then the event. A conflict gives count = 1; a timeout or no-source event leaves its sticky set.
- Count saturation: at 8'hFF further conflicts leave the count at 8'hFF, but `conflict_irq` still pulses.
- Write to any other address: no effect.
- Width rules:
  - Indices are 4 bits wide.
  - Unused `src_avail` bits are tied low by the instantiating module.
  - Only `ab` is compared, all 8 bits.

Test Plan:
- Single claim: 8-cycle read, `src_avail` = 8'b0000_0100, source 2 data 16'hA55A -> `db_oe` rises 2 edges after `read_qualified`; `db_out` = 16'hA55A; `grant` = 8'h04; `db_oe` falls on the edge after `read_qualified` drops; TURN_CYC = 1 idle cycle follows.
- Conflict: `src_avail` = 8'b1001_0010 -> source 1 granted; `conflict_irq` pulses once; a subsequent read of 8'hF0 returns 16'h1001.
- Empty read: `src_avail` = 0 at `ab` = 8'h20 -> `db_out` = 16'h3333; next status read bit 9 = 1, `grant` = 0.
- Watchdog: `read_qualified` held high for 300 cycles -> `db_oe` drops after 255 DRIVE cycles and stays low until `read_qualified` falls; status bit 8 = 1.
- Clear race: write 8'hF0 with `db_in` = 16'h0001 on the same edge a conflict is detected -> status reads 16'hX001 (count 1); after a conflict-free clear, status reads 16'h0000.
- Reset mid-DRIVE: assert `reset` low during DRIVE -> `db_oe` = 0 immediately, status = 0; a read after release behaves as a fresh first read.

Source files
------------

// File: rtl/db_read_arbiter.sv
// Read-return arbiter for the DSP external 16-bit data bus.
// Each read runs settle -> claim sample -> grant -> drive -> turnaround, and
// conflicts, empty reads and stuck reads are logged in a DSP-readable status word.
module db_read_arbiter #(
    parameter int          NUM_SRC      = 8,
    parameter logic [7:0]  STAT_ADDR    = 8'hF0,
    parameter int          TURN_CYC     = 1,
    parameter int          TIMEOUT      = 255,
    parameter logic [15:0] DEFAULT_DATA = 16'h3333
) (
    input  logic                    xclk,
    input  logic                    reset,
    input  logic                    read_qualified,
    input  logic                    write_qualified,
    input  logic [7:0]              ab,
    input  logic [15:0]             db_in,
    input  logic [NUM_SRC-1:0]      src_avail,
    input  logic [16*NUM_SRC-1:0]   src_data,
    output logic [15:0]             db_out,
    output logic                    db_oe,
    output logic [NUM_SRC-1:0]      grant,
    output logic                    conflict_irq
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_DRIVE   = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_TURN    = 3'd4;

    // Where DRIVE refreshes db_out from, fixed at the SETTLE exit edge.
    localparam logic [1:0] M_SRC  = 2'd0;
    localparam logic [1:0] M_STAT = 2'd1;
    localparam logic [1:0] M_DFLT = 2'd2;

    logic [2:0]               state_q, state_d;
    logic [15:0]              db_out_q, db_out_d;
    logic                     db_oe_q, db_oe_d;
    logic [NUM_SRC-1:0]       grant_q, grant_d;
    logic                     irq_q, irq_d;
    logic [1:0]               mode_q, mode_d;
    logic [3:0]               sel_q, sel_d;
    logic [7:0]               wd_q, wd_d;
    logic [2:0]               turn_q, turn_d;

    logic [7:0]               cnt_q, cnt_d;
    logic                     to_q, to_d;
    logic                     nosrc_q, nosrc_d;
    logic [3:0]               lw_q, lw_d;

    logic [NUM_SRC-1:0][15:0] src_vec;
    logic [3:0]               low_idx;
    logic [15:0]              low_data, sel_data, stat_word;
    logic                     is_stat, any_src, multi, settle_exit, wd_fire, clr;
    logic                     unused_db;

    assign src_vec     = src_data;
    assign unused_db   = ^db_in[15:1];
    assign is_stat     = (ab == STAT_ADDR);
    assign any_src     = |src_avail;
    // Clearing the lowest set bit leaves something behind only if two or more were set.
    assign multi       = |(src_avail & (src_avail - NUM_SRC'(1)));
    assign settle_exit = (state_q == S_SETTLE);
    assign wd_fire     = (state_q == S_DRIVE) && read_qualified && (wd_q == 8'(TIMEOUT-1));
    assign clr         = write_qualified && is_stat && db_in[0];
    assign stat_word   = {lw_q, 2'b00, nosrc_q, to_q, cnt_q};

    // Lowest-index claimant and the data muxes for it and for the frozen selection.
    always_comb begin
        low_idx  = '0;
        low_data = '0;
        sel_data = '0;
        for (int i = NUM_SRC-1; i >= 0; i--) begin
            if (src_avail[i]) low_idx = 4'(i);
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (low_idx == 4'(i)) low_data = src_vec[i];
            if (sel_q == 4'(i))   sel_data = src_vec[i];
        end
    end

    // Read sequencer: next state, bus drive, grant and watchdog/turnaround counters.
    always_comb begin
        state_d  = state_q;
        db_out_d = db_out_q;
        db_oe_d  = db_oe_q;
        grant_d  = grant_q;
        mode_d   = mode_q;
        sel_d    = sel_q;
        wd_d     = wd_q;
        turn_d   = turn_q;
        irq_d    = settle_exit && !is_stat && multi;
        case (state_q)
            S_IDLE: begin
                if (read_qualified) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                wd_d   = '0;
                turn_d = '0;
                if (is_stat) begin
                    mode_d   = M_STAT;
                    grant_d  = '0;
                    db_out_d = stat_word;
                end else if (any_src) begin
                    mode_d   = M_SRC;
                    sel_d    = low_idx;
                    grant_d  = NUM_SRC'(1) << low_idx;
                    db_out_d = low_data;
                end else begin
                    mode_d   = M_DFLT;
                    grant_d  = '0;
                    db_out_d = DEFAULT_DATA;
                end
                if (read_qualified) begin
                    state_d = S_DRIVE;
                    db_oe_d = 1'b1;
                end else begin
                    // Read withdrawn during settle: never drive the pad.
                    state_d = S_TURN;
                    db_oe_d = 1'b0;
                    grant_d = '0;
                end
            end
            S_DRIVE: begin
                if (!read_qualified) begin
                    state_d = S_TURN;
                    db_oe_d = 1'b0;
                    grant_d = '0;
                    turn_d  = '0;
                end else if (wd_fire) begin
                    state_d = S_RELEASE;
                    db_oe_d = 1'b0;
                    grant_d = '0;
                end else begin
                    wd_d = wd_q + 8'd1;
                    case (mode_q)
                        M_SRC:   db_out_d = sel_data;
                        M_STAT:  db_out_d = stat_word;
                        default: db_out_d = DEFAULT_DATA;
                    endcase
                end
            end
            S_RELEASE: begin
                if (!read_qualified) begin
                    state_d = S_TURN;
                    turn_d  = '0;
                end
            end
            S_TURN: begin
                db_oe_d = 1'b0;
                grant_d = '0;
                if (turn_q == 3'(TURN_CYC-1)) state_d = read_qualified ? S_SETTLE : S_IDLE;
                else                          turn_d  = turn_q + 3'd1;
            end
            default: begin
                state_d = S_IDLE;
                db_oe_d = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    // Status word update: a same-edge clear is applied before any new event.
    always_comb begin
        cnt_d   = cnt_q;
        to_d    = to_q;
        nosrc_d = nosrc_q;
        lw_d    = lw_q;
        if (clr) begin
            cnt_d   = '0;
            to_d    = 1'b0;
            nosrc_d = 1'b0;
            lw_d    = '0;
        end
        if (settle_exit && !is_stat && multi) begin
            if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
            lw_d = low_idx;
        end
        if (settle_exit && !is_stat && !any_src) nosrc_d = 1'b1;
        if (wd_fire) to_d = 1'b1;
    end

    // State and output registers; reset drops db_oe without waiting for a clock.
    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            db_out_q <= '0;
            db_oe_q  <= 1'b0;
            grant_q  <= '0;
            irq_q    <= 1'b0;
            mode_q   <= M_DFLT;
            sel_q    <= '0;
            wd_q     <= '0;
            turn_q   <= '0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
            nosrc_q  <= 1'b0;
            lw_q     <= '0;
        end else begin
            state_q  <= state_d;
            db_out_q <= db_out_d;
            db_oe_q  <= db_oe_d;
            grant_q  <= grant_d;
            irq_q    <= irq_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            wd_q     <= wd_d;
            turn_q   <= turn_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            nosrc_q  <= nosrc_d;
            lw_q     <= lw_d;
        end
    end

    assign db_out       = db_out_q;
    assign db_oe        = db_oe_q;
    assign grant        = grant_q;
    assign conflict_irq = irq_q;

endmodule

// File: tb/tb_db_read_arbiter.sv
// Directed bench for db_read_arbiter: a read-level model (status counters plus
// expected bus/grant/irq per cycle) checked every cycle, plus literal pins.
module tb_db_read_arbiter;

    localparam int NS = 8;

    logic              xclk = 1'b0;
    logic              reset;
    logic              read_qualified, write_qualified;
    logic [7:0]        ab;
    logic [15:0]       db_in;
    logic [NS-1:0]     src_avail;
    logic [16*NS-1:0]  src_data;
    logic [15:0]       db_out;
    logic              db_oe;
    logic [NS-1:0]     grant;
    logic              conflict_irq;

    logic [15:0]       srcd [NS];

    db_read_arbiter dut (
        .xclk(xclk), .reset(reset), .read_qualified(read_qualified),
        .write_qualified(write_qualified), .ab(ab), .db_in(db_in),
        .src_avail(src_avail), .src_data(src_data), .db_out(db_out),
        .db_oe(db_oe), .grant(grant), .conflict_irq(conflict_irq)
    );

    always #5 xclk = ~xclk;

    always_comb begin
        src_data = '0;
        for (int i = 0; i < NS; i++) src_data[16*i +: 16] = srcd[i];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the status register.
    int m_cnt, m_lw;
    bit m_to, m_nos;

    // Expected outputs for the current cycle.
    bit            chk_en = 0;
    logic          e_oe = 0, e_irq = 0;
    logic [NS-1:0] e_g = '0;
    logic [15:0]   e_dout = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] stat_word();
        return {4'(m_lw), 2'b00, m_nos, m_to, 8'(m_cnt)};
    endfunction

    function automatic int lowest(input logic [NS-1:0] v);
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic void model_clear();
        m_cnt = 0; m_lw = 0; m_to = 0; m_nos = 0;
    endfunction

    function automatic void model_settle(input logic [7:0] a, input logic [NS-1:0] av);
        if (a != 8'hF0) begin
            if (av == '0) m_nos = 1;
            else if ($countones(av) > 1) begin
                if (m_cnt < 255) m_cnt++;
                m_lw = lowest(av);
            end
        end
    endfunction

    // Per-cycle comparison of the DUT against the expected outputs.
    always @(negedge xclk) begin
        if (chk_en) begin
            chk("db_oe", 32'(db_oe), 32'(e_oe));
            chk("grant", 32'(grant), 32'(e_g));
            chk("conflict_irq", 32'(conflict_irq), 32'(e_irq));
            if (e_oe) chk("db_out", 32'(db_out), 32'(e_dout));
        end
    end

    task automatic tick();
        @(posedge xclk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [NS-1:0] av, input int n,
                           input bit abort, output logic [15:0] got, output logic [NS-1:0] got_g);
        logic [15:0]   d;
        logic [NS-1:0] g;
        bit            conf, src_mode;
        int            idx;
        idx = lowest(av); src_mode = 0; g = '0; got = '0; got_g = '0;
        conf = (a != 8'hF0) && ($countones(av) > 1);
        ab = a; src_avail = av; read_qualified = 1'b1;
        tick();
        if (a == 8'hF0) d = stat_word();
        else if (idx >= 0) begin d = srcd[idx]; g = NS'(1) << idx; src_mode = 1; end
        else d = 16'h3333;
        if (abort) read_qualified = 1'b0;
        tick();
        model_settle(a, av);
        if (abort) begin
            e_irq = conf;
            tick();
            e_irq = 0; src_avail = '0;
            return;
        end
        for (int k = 1; k <= n; k++) begin
            e_oe = 1; e_g = g; e_irq = conf && (k == 1); e_dout = d;
            if (k == 1) begin got = db_out; got_g = grant; end
            if (k == 2) begin
                src_avail = ~av;
                if (src_mode) srcd[idx] = srcd[idx] ^ 16'hFFFF;
            end
            read_qualified = (k < n);
            tick();
            if (src_mode) d = srcd[idx];
        end
        e_oe = 0; e_g = '0; e_irq = 0; src_avail = '0;
        tick();
    endtask

    // Stuck read with a status clear landing on the same edge as the timeout.
    task automatic do_wd(input logic [7:0] a, input logic [NS-1:0] av, input int rel, output int oe_cnt);
        logic [15:0]   d;
        logic [NS-1:0] g;
        int            idx;
        oe_cnt = 0;
        ab = a; src_avail = av; read_qualified = 1'b1;
        tick();
        idx = lowest(av); d = srcd[idx]; g = NS'(1) << idx;
        tick();
        model_settle(a, av);
        for (int k = 1; k <= 255; k++) begin
            e_oe = 1; e_g = g; e_irq = 0; e_dout = d;
            if (db_oe) oe_cnt++;
            if (k == 255) begin write_qualified = 1; ab = 8'hF0; db_in = 16'h0001; end
            tick();
        end
        model_clear(); m_to = 1;
        write_qualified = 0; db_in = '0; ab = a;
        for (int j = 1; j <= rel; j++) begin
            e_oe = 0; e_g = '0; e_irq = 0;
            if (db_oe) oe_cnt++;
            read_qualified = (j < rel);
            tick();
        end
        src_avail = '0;
        tick();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input int n);
        ab = a; db_in = d; write_qualified = 1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (a == 8'hF0 && d[0]) model_clear();
        end
        write_qualified = 0; db_in = '0;
        tick();
    endtask

    task automatic do_reset_mid_drive();
        ab = 8'h12; src_avail = 8'h08; read_qualified = 1'b1;
        tick();
        tick();
        e_oe = 1; e_g = 8'h08; e_irq = 0; e_dout = srcd[3];
        tick();
        chk_en = 0;
        #1 reset = 1'b0;
        #1;
        chk("rst_oe_async", 32'(db_oe), 32'd0);
        chk("rst_grant_async", 32'(grant), 32'd0);
        chk("rst_dout_async", 32'(db_out), 32'd0);
        model_clear();
        read_qualified = 0; src_avail = '0;
        e_oe = 0; e_g = '0; e_irq = 0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_en = 1;
    endtask

    logic [15:0]   got;
    logic [NS-1:0] gg;
    int            oe_cnt;

    initial begin
        for (int i = 0; i < NS; i++) srcd[i] = {4'(i), 12'hBC0 + 12'(i)};
        srcd[2] = 16'hA55A;
        reset = 1'b0; read_qualified = 0; write_qualified = 0;
        ab = '0; db_in = '0; src_avail = '0;
        model_clear();
        tick();
        tick();
        chk("reset_oe", 32'(db_oe), 32'd0);
        chk("reset_dout", 32'(db_out), 32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_irq", 32'(conflict_irq), 32'd0);
        reset = 1'b1;
        tick();
        chk_en = 1;

        // Single claim, 8 cycles of read_qualified.
        do_read(8'h10, 8'b0000_0100, 7, 0, got, gg);
        chk("single_data", 32'(got), 32'h0000_A55A);
        chk("single_grant", 32'(gg), 32'h04);

        // Conflict: lowest index wins, then status shows count 1, winner 1.
        do_read(8'h11, 8'b1001_0010, 3, 0, got, gg);
        chk("conflict_grant", 32'(gg), 32'h02);
        do_read(8'hF0, 8'b0000_0110, 2, 0, got, gg);
        chk("conflict_status", 32'(got), 32'h1001);

        // Empty read returns the default word and sets the no-source sticky.
        do_read(8'h20, 8'h00, 3, 0, got, gg);
        chk("empty_data", 32'(got), 32'h3333);
        chk("empty_grant", 32'(gg), 32'h00);
        do_read(8'hF0, 8'h00, 2, 0, got, gg);
        chk("empty_status_b9", 32'(got[9]), 32'd1);

        // Aborted conflicting read still logs the conflict.
        do_read(8'h30, 8'b0110_0000, 0, 1, got, gg);
        // Writes that must not clear anything.
        do_write(8'h20, 16'h0001, 2);
        do_write(8'hF0, 16'h0000, 2);
        do_read(8'hF0, 8'h00, 2, 0, got, gg);
        chk("abort_status", 32'(got), 32'h5202);

        // Watchdog with a same-edge clear: timeout sticky survives.
        do_wd(8'h40, 8'b0000_1000, 45, oe_cnt);
        chk("wd_oe_cycles", 32'(oe_cnt), 32'd255);
        do_read(8'hF0, 8'h00, 2, 0, got, gg);
        chk("wd_status", 32'(got), 32'h0100);

        // Conflict count saturation (irq still pulses each time).
        for (int r = 0; r < 256; r++) do_read(8'h50, 8'b1100_0000, 1, 0, got, gg);
        do_read(8'hF0, 8'h00, 2, 0, got, gg);
        chk("sat_status", 32'(got), 32'h61FF);

        // Multi-cycle clear.
        do_write(8'hF0, 16'h0001, 3);
        do_read(8'hF0, 8'h00, 2, 0, got, gg);
        chk("clear_status", 32'(got), 32'h0000);

        // Reset in DRIVE after logging a conflict; next read is a fresh one.
        do_read(8'h13, 8'b0000_0011, 2, 0, got, gg);
        do_reset_mid_drive();
        do_read(8'hF0, 8'h00, 2, 0, got, gg);
        chk("post_reset_status", 32'(got), 32'h0000);
        do_read(8'h10, 8'b0000_0100, 3, 0, got, gg);
        chk("post_reset_grant", 32'(gg), 32'h04);

        tick();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
